// File: rtl/v_down_timer.sv
// ---------------------------------------------------------------------------
// v_down_timer
//
// Loadable signed down-counter with one-shot and auto-reload modes.
//
// A LOAD with a non-negative D starts a count from D; the counter decrements
// on every CE=1 cycle while running and raises a single-cycle terminal-count
// pulse (TC) on the CE=1 cycle that finds it at zero. In one-shot mode the
// timer then parks in DONE with Q=0; in auto-reload mode it restarts from the
// last valid load value. A LOAD with a negative D is rejected: the timer goes
// idle with Q=0 and the sticky ERR flag is set until the next CLR.
//
// Ports
//   C     in   clock, rising edge
//   CLR   in   asynchronous reset, active high
//   LOAD  in   load D / MODE and start (priority over everything else)
//   D     in   signed start / reload value, WIDTH bits
//   MODE  in   0 = one-shot, 1 = auto-reload (sampled only with LOAD)
//   CE    in   count enable; 0 pauses a running count
//   Q     out  current count (registered, never negative)
//   TC    out  terminal-count pulse (registered)
//   BUSY  out  high while the timer is running (state decode)
//   ERR   out  sticky negative-load flag (registered)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module v_down_timer #(
    parameter int WIDTH = 4
) (
    input  logic                    C,
    input  logic                    CLR,
    input  logic                    LOAD,
    input  logic signed [WIDTH-1:0] D,
    input  logic                    MODE,
    input  logic                    CE,
    output logic signed [WIDTH-1:0] Q,
    output logic                    TC,
    output logic                    BUSY,
    output logic                    ERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [WIDTH-1:0] ZERO = '0;
    localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1);

    state_t                  state_q,  state_d;
    logic signed [WIDTH-1:0] count_q,  count_d;
    logic signed [WIDTH-1:0] reload_q, reload_d;
    logic                    mode_q,   mode_d;
    logic                    tc_q,     tc_d;
    logic                    err_q,    err_d;

    // The sign bit alone decides whether a load is accepted.
    logic load_neg;
    assign load_neg = D[WIDTH-1];

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        err_d    = err_q;
        tc_d     = 1'b0;   // TC is a pulse: low unless set below

        if (LOAD) begin
            // LOAD outranks CE and terminal-count handling.
            if (load_neg) begin
                err_d   = 1'b1;
                state_d = IDLE;
                count_d = ZERO;
            end else begin
                count_d  = D;
                reload_d = D;
                mode_d   = MODE;
                state_d  = RUN;
            end
        end else if (state_q == RUN && CE) begin
            if (count_q > ZERO) begin
                // Decrement only above zero: Q can never underflow or wrap.
                count_d = count_q - ONE;
            end else begin
                tc_d = 1'b1;
                if (mode_q) begin
                    // With RELOAD=0 this re-fires TC on every enabled cycle.
                    count_d = reload_q;
                end else begin
                    state_d = DONE;
                end
            end
        end
        // IDLE / DONE, or RUN with CE=0: everything holds, TC drops.
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge C or posedge CLR) begin
        if (CLR) begin
            state_q  <= IDLE;
            count_q  <= ZERO;
            reload_q <= ZERO;
            mode_q   <= 1'b0;
            tc_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            tc_q     <= tc_d;
            err_q    <= err_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: registers or a pure decode of the state register
    // -----------------------------------------------------------------------
    assign Q    = count_q;
    assign TC   = tc_q;
    assign ERR  = err_q;
    assign BUSY = (state_q == RUN);

endmodule
